fir_golden_checker: RTL

FIR_GOLDEN_CHECKER -- requirements
Module: fir_golden_checker

---
 rtl/fir_golden_checker.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fir_golden_checker.sv
// Checks a FIR output stream against a preloaded golden table: skips LAT fill samples, then compares Data_Num samples.
// Optional macro CHK_HALT_ON_ERR_EN: finish the run on the first mismatch instead of comparing every sample.
module fir_golden_checker #(
  parameter int macWL    = 20,
  parameter int Data_Num = 500,
  parameter int LAT      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              gold_we,
  input  logic [$clog2(Data_Num)-1:0]       gold_addr,
  input  logic signed [macWL-1:0]           gold_wdata,
  input  logic                              start,
  input  logic                              data_valid,
  input  logic signed [macWL-1:0]           data_in,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [$clog2(Data_Num+1)-1:0]     err_cnt,
  output logic [$clog2(Data_Num)-1:0]       first_err_idx,
  output logic                              first_err_vld,
  output logic [$clog2(Data_Num+1)-1:0]     sample_cnt
);

  localparam int AW = $clog2(Data_Num);
  localparam int CW = $clog2(Data_Num + 1);
  localparam int SW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           skip_q, skip_d;
  logic [CW-1:0]           sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]           err_cnt_q, err_cnt_d;
  logic [AW-1:0]           first_err_idx_q, first_err_idx_d;
  logic                    first_err_vld_q, first_err_vld_d;

  logic signed [macWL-1:0] gold_mem [Data_Num];
  logic signed [macWL-1:0] gold_rd;
  logic                    mismatch;
  logic                    last_cmp;
  logic                    accept_cfg;

  assign accept_cfg = (state_q == IDLE) || (state_q == DONE);

  // Golden table has no reset so a mid-run abort keeps the loaded reference.
  always_ff @(posedge clk) begin
    if (gold_we && accept_cfg) begin
      gold_mem[gold_addr] <= gold_wdata;
    end
  end

  assign gold_rd  = gold_mem[sample_cnt_q[AW-1:0]];
  assign mismatch = (data_in != gold_rd);
  assign last_cmp = (sample_cnt_q == CW'(Data_Num - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      skip_q          <= '0;
      sample_cnt_q    <= '0;
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      skip_q          <= skip_d;
      sample_cnt_q    <= sample_cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (LAT == 0) ? CHECK : SKIP;
        end
      end
      SKIP: begin
        if (data_valid && (skip_q == SW'(LAT - 1))) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (data_valid) begin
          if (last_cmp) begin
            state_d = DONE;
          end
`ifdef CHK_HALT_ON_ERR_EN
          if (mismatch) begin
            state_d = DONE;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters and flags move on the same edge that samples data_valid.
  always_comb begin
    skip_d          = skip_q;
    sample_cnt_d    = sample_cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          skip_d          = '0;
          sample_cnt_d    = '0;
          err_cnt_d       = '0;
          first_err_vld_d = 1'b0;
        end
      end
      SKIP: begin
        if (data_valid) begin
          skip_d = skip_q + SW'(1);
        end
      end
      CHECK: begin
        if (data_valid) begin
          sample_cnt_d = sample_cnt_q + CW'(1);
          if (mismatch) begin
            if (err_cnt_q != CW'(Data_Num)) begin
              err_cnt_d = err_cnt_q + CW'(1);
            end
            if (!first_err_vld_q) begin
              first_err_idx_d = sample_cnt_q[AW-1:0];
              first_err_vld_d = 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy          = (state_q == SKIP) || (state_q == CHECK);
    done          = (state_q == DONE);
    pass          = (state_q == DONE) && (err_cnt_q == '0);
    err_cnt       = err_cnt_q;
    sample_cnt    = sample_cnt_q;
    first_err_idx = first_err_idx_q;
    first_err_vld = first_err_vld_q;
  end

endmodule
